// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_e  : sequencer FSM states
//   Def*           : default values for the top-level parameters
//   OpcodeWidth    : width of the opcode field at the top of each instruction
//   sat_inc32      : saturating 32-bit increment for the optional perf counters
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StDrain  = 2'd2,
        StHalted = 2'd3
    } fetch_state_e;

    localparam int unsigned DefAddrWidth   = 11;
    localparam int unsigned DefDataWidth   = 16;
    localparam int unsigned DefReadLatency = 2;
    localparam int unsigned OpcodeWidth    = 5;

    localparam logic [OpcodeWidth-1:0] DefHaltOpcode = 5'b00000;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Skid FIFO holding captured instructions until decode accepts them.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empty the FIFO (wins over push/pop on the same edge)
//   push_i/data_i : write one entry
//   pop_i         : drop the head entry (ignored when empty)
//   data_o        : head entry
//   count_o       : current occupancy
//   empty_o       : occupancy is zero
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        // A push into a full FIFO is only safe when the head leaves on the same edge.
        do_push = push_i && ((count_q != CntW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_comb begin
        data_o  = mem_q[rd_ptr_q];
        count_o = count_q;
        empty_o = (count_q == '0);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: streams reads from a fixed-latency program memory
// into a skid FIFO and hands instructions to decode with a valid/ready handshake.
// Supports redirects (flush + new PC) and stops on a HALT opcode.
//   clka, rst_n              : clock, asynchronous active-low reset
//   start, start_addr        : begin fetching (accepted in IDLE or HALTED)
//   redir_valid, redir_addr  : redirect in FETCH/DRAIN
//   mem_addr, mem_data       : program memory address out, read data in
//   instr_valid/ready/data/pc: instruction handshake to decode
//   busy, done               : FETCH or DRAIN / HALTED
// Optional build macro FETCH_SEQ_PERF_EN adds saturating counters stall_cnt
// (instr_valid && !instr_ready cycles) and fetch_cnt (reads issued).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    // Legal range 1..2.
    parameter int unsigned READ_LATENCY = DefReadLatency,
    parameter logic [OpcodeWidth-1:0] HALT_OPCODE = DefHaltOpcode
) (
    input  logic                  clka,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  redir_valid,
    input  logic [ADDR_WIDTH-1:0] redir_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  busy,
    output logic                  done
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           fetch_cnt
`endif
);

    localparam int unsigned FifoDepth = READ_LATENCY + 1;
    localparam int unsigned FifoW     = DATA_WIDTH + ADDR_WIDTH;
    localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);
    localparam int unsigned OccW      = 4;

    fetch_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

    // Read tags: stage READ_LATENCY-1 is the oldest and lines up with mem_data.
    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [ADDR_WIDTH-1:0]   tag_pc_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   tag_pc_d [READ_LATENCY];

    logic                fifo_empty;
    logic [FifoCntW-1:0] fifo_count;
    logic [FifoW-1:0]    fifo_head;
    logic                fifo_push;
    logic                pop;

    logic            redirect;
    logic            start_ok;
    logic            capture;
    logic            halt_cap;
    logic            issue;
    logic [OccW-1:0] inflight;
    logic [OccW-1:0] occ;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight = inflight + OccW'(tag_vld_q[i]);
        end
    end

    always_comb begin
        pop      = instr_valid && instr_ready;
        redirect = redir_valid && ((state_q == StFetch) || (state_q == StDrain));
        start_ok = start && ((state_q == StIdle) || (state_q == StHalted));
        capture  = tag_vld_q[READ_LATENCY-1] && !redirect;
        halt_cap = capture && (state_q == StFetch) &&
                   (mem_data[DATA_WIDTH-1 -: OpcodeWidth] == HALT_OPCODE);
        // Every in-flight read already owns a FIFO slot. The entry leaving this
        // cycle frees its slot now, which keeps one issue per cycle in steady state.
        occ      = inflight + OccW'(fifo_count) - OccW'(pop);
        issue    = (state_q == StFetch) && !redirect && !halt_cap &&
                   (occ < OccW'(FifoDepth));
        fifo_push = capture;
    end

    // Next-state and PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle, StHalted: begin
                if (start_ok) begin
                    state_d = StFetch;
                    pc_d    = start_addr;
                end
            end
            StFetch: begin
                if (redirect) begin
                    pc_d = redir_addr;
                end else if (halt_cap) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (redirect) begin
                    state_d = StFetch;
                    pc_d    = redir_addr;
                end else if (pop && (fifo_count == FifoCntW'(1))) begin
                    // Younger reads were discarded, so the last entry is the halt.
                    state_d = StHalted;
                end
            end
            default: state_d = StIdle;
        endcase
        if (issue) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    // Tag pipeline: redirect and halt both kill every younger read.
    always_comb begin
        tag_vld_d = '0;
        tag_pc_d  = tag_pc_q;
        if (!redirect && !halt_cap) begin
            tag_vld_d[0] = issue;
            tag_pc_d[0]  = pc_q;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_pc_d[i]  = tag_pc_q[i-1];
            end
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                tag_pc_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tag_vld_q <= tag_vld_d;
            tag_pc_q  <= tag_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (FifoW),
        .DEPTH (FifoDepth)
    ) u_fifo (
        .clk_i   (clka),
        .rst_ni  (rst_n),
        .flush_i (redirect),
        .push_i  (fifo_push),
        .data_i  ({mem_data, tag_pc_q[READ_LATENCY-1]}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        mem_addr    = pc_q;
        instr_valid = !fifo_empty;
        instr_data  = instr_valid ? fifo_head[FifoW-1 -: DATA_WIDTH] : '0;
        instr_pc    = instr_valid ? fifo_head[ADDR_WIDTH-1:0] : '0;
        busy        = (state_q == StFetch) || (state_q == StDrain);
        done        = (state_q == StHalted);
    end

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            if (instr_valid && !instr_ready) begin
                stall_cnt_q <= sat_inc32(stall_cnt_q);
            end
            if (issue) begin
                fetch_cnt_q <= sat_inc32(fetch_cnt_q);
            end
        end
    end

    always_comb begin
        stall_cnt = stall_cnt_q;
        fetch_cnt = fetch_cnt_q;
    end
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, program-memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, instruction width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, memory read latency in cycles (legal 1..2).
REQ-004 SHALL have parameter HALT_OPCODE, default 5'b00000, matched against instr[DATA_WIDTH-1:DATA_WIDTH-5].
REQ-005 clka  in  1  single clock, all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  pulse that begins fetching from start_addr.
REQ-008 start_addr  in  ADDR_WIDTH  first fetch address.
REQ-009 redir_valid  in  1  branch/jump redirect request.
REQ-010 redir_addr  in  ADDR_WIDTH  redirect target.
REQ-011 mem_addr  out  ADDR_WIDTH  address to program memory.
REQ-012 mem_data  in  DATA_WIDTH  program memory read data.
REQ-013 instr_valid / instr_ready  out / in  1 / 1  instruction handshake to decode.
REQ-014 instr_data  out  DATA_WIDTH  delivered instruction.
REQ-015 instr_pc  out  ADDR_WIDTH  address of delivered instruction.
REQ-016 busy / done  out / out  1 / 1  fetching or draining / halted.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, HALTED.
REQ-018 IDLE->FETCH on start; PC loaded with start_addr; start ignored outside IDLE and HALTED.
REQ-019 In FETCH, SHALL issue one read per cycle (mem_addr=PC, PC+1) only when in-flight count + FIFO occupancy < READ_LATENCY+1.
REQ-020 SHALL tag each issued read in a READ_LATENCY-deep shift register (valid, pc); mem_data captured into the skid FIFO when the tag exits.
REQ-021 FIFO depth READ_LATENCY+1; SHALL never overflow; instr_valid = FIFO non-empty; pop on instr_valid && instr_ready.
REQ-022 instr_data/instr_pc SHALL remain stable while instr_valid && !instr_ready.
REQ-023 PC SHALL wrap from 2^ADDR_WIDTH-1 to 0 without error.
REQ-024 redir_valid in FETCH or DRAIN: clear FIFO and all in-flight tags same edge, PC=redir_addr, state FETCH; no stale instruction delivered afterward.
REQ-025 redir_valid coincident with a pop: pop is honoured, then flush applies.
REQ-026 Captured instruction whose opcode equals HALT_OPCODE: stop issuing, discard younger in-flight reads, state DRAIN; it is still delivered.
REQ-027 DRAIN->HALTED when the halt instruction is popped; done=1 in HALTED; start from HALTED behaves as from IDLE.
REQ-028 busy=1 in FETCH and DRAIN only.

Reset
REQ-029 On rst_n low: state IDLE, PC=0, mem_addr=0, FIFO empty, tags cleared, instr_valid=0, instr_data=0, instr_pc=0, busy=0, done=0.
REQ-030 Reset mid-fetch SHALL discard all in-flight data; first post-reset capture only after a new start.

Configuration
REQ-031 Macro FETCH_SEQ_PERF_EN: when defined, adds outputs stall_cnt[31:0] (cycles instr_valid && !instr_ready) and fetch_cnt[31:0] (reads issued), saturating, reset to 0; when undefined, ports and counters absent and behaviour otherwise identical.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, default parameter constants and HALT_OPCODE default.
REQ-033 Skid FIFO SHALL be sub-module fetch_fifo (parameterised width/depth, push, pop, flush, count).

Verification
REQ-034 start, start_addr=0x010, instr_ready=1, no halt -> instr_pc 0x010,0x011,... one per cycle after READ_LATENCY+1 cycles.
REQ-035 instr_ready=0 for 10 cycles mid-stream -> issue stops at FIFO capacity, no loss/duplication, order resumes on ready.
REQ-036 redir_valid to 0x200 with 2 reads in flight -> next delivered instr_pc=0x200, no 0x0xx after.
REQ-037 start_addr=0x7FE -> instr_pc 0x7FE,0x7FF,0x000.
REQ-038 HALT at 0x013 -> 0x013 delivered last, done=1, busy=0; rst_n low mid-FETCH -> all outputs at reset values.
